// File: rtl/vga_fill_engine.sv
// vga_fill_engine
//   Bus-master rectangle fill. Latches a command in IDLE, clips the
//   rectangle to the visible area in CALC, then issues one single-cycle VRAM
//   write per pixel in raster order through the controller's VRAM window.
//   The local bus is shared with the CPU through bus_req/bus_gnt.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   start, abort          command strobe (IDLE only), cancel (CALC/WRITE)
//   x0, y0, width, height rectangle origin and size in pixels
//   color                 12-bit {R,G,B} fill colour
//   busy, done, err       status: busy while running, done pulse, sticky err
//   bus_req, bus_gnt      local bus arbitration
//   m_sel, m_addr, m_we, m_wdata  master side of the controller's slave port
module vga_fill_engine #(
  parameter int              XLEN      = 32,
  parameter int              H_ACTIVE  = 640,
  parameter int              V_ACTIVE  = 480,
  parameter logic [XLEN-1:0] VRAM_BASE = 32'h0010_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [9:0]      x0,
  input  logic [8:0]      y0,
  input  logic [9:0]      width,
  input  logic [8:0]      height,
  input  logic [11:0]     color,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            bus_req,
  input  logic            bus_gnt,
  output logic            m_sel,
  output logic [XLEN-1:0] m_addr,
  output logic [2:0]      m_we,
  output logic [XLEN-1:0] m_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WRITE, S_FIN} state_t;

  typedef struct packed {
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [9:0]  width;
    logic [8:0]  height;
    logic [11:0] color;
  } fill_cmd_t;

  state_t    state;
  fill_cmd_t cmd;

  // Walk state: row_base is the pixel index of the current row's first
  // column; xoff/yoff count within the clipped rectangle.
  logic [18:0] row_base;
  logic [9:0]  xoff;
  logic [8:0]  yoff;
  logic [10:0] ncols;
  logic [10:0] nrows;

  // CALC-stage combinational clipping (11-bit sums cannot wrap)
  logic [10:0] x_sum, y_sum, xe, ye;
  logic        off_screen, empty;
  logic [18:0] base_calc;

  always_comb begin
    x_sum      = {1'b0, cmd.x0} + {1'b0, cmd.width};
    y_sum      = {2'b0, cmd.y0} + {2'b0, cmd.height};
    xe         = (x_sum > 11'(H_ACTIVE)) ? 11'(H_ACTIVE) : x_sum;
    ye         = (y_sum > 11'(V_ACTIVE)) ? 11'(V_ACTIVE) : y_sum;
    off_screen = ({1'b0, cmd.x0} >= 11'(H_ACTIVE)) || ({2'b0, cmd.y0} >= 11'(V_ACTIVE));
    empty      = (cmd.width == '0) || (cmd.height == '0);
    // Constant multiply, only evaluated once per command
    base_calc  = 19'(cmd.y0) * 19'(H_ACTIVE) + 19'(cmd.x0);
  end

  logic        last_col, last_row, in_write;
  logic [18:0] pix_idx;

  assign last_col = ({1'b0, xoff} == ncols - 11'd1);
  assign last_row = ({2'b0, yoff} == nrows - 11'd1);
  assign pix_idx  = row_base + 19'(xoff);
  assign in_write = (state == S_WRITE);

  // Bus side follows the grant combinationally; abort suppresses the write
  // in the same cycle so nothing lands after a cancel.
  assign m_sel   = in_write & bus_gnt & ~abort;
  assign m_we    = m_sel ? 3'b100 : 3'b000;
  assign m_addr  = in_write ? (VRAM_BASE | XLEN'(pix_idx)) : '0;
  assign m_wdata = in_write ? XLEN'(cmd.color) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cmd      <= '0;
      row_base <= '0;
      xoff     <= '0;
      yoff     <= '0;
      ncols    <= '0;
      nrows    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bus_req  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cmd   <= '{x0: x0, y0: y0, width: width, height: height, color: color};
            busy  <= 1'b1;
            state <= S_CALC;
          end
        end

        S_CALC: begin
          row_base <= base_calc;
          xoff     <= '0;
          yoff     <= '0;
          ncols    <= xe - {1'b0, cmd.x0};
          nrows    <= ye - {2'b0, cmd.y0};
          if (abort || off_screen) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_FIN;
          end else if (empty) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b0;
            state <= S_FIN;
          end else begin
            bus_req <= 1'b1;
            state   <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (abort) begin
            bus_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= S_FIN;
          end else if (bus_gnt) begin
            // Position only moves on an accepted write; a dropped grant
            // simply re-presents the same pixel.
            if (last_col) begin
              xoff     <= '0;
              yoff     <= yoff + 9'd1;
              row_base <= row_base + 19'(H_ACTIVE);
              if (last_row) begin
                bus_req <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                err     <= 1'b0;
                state   <= S_FIN;
              end
            end else begin
              xoff <= xoff + 10'd1;
            end
          end
        end

        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fill_engine.sv
module tb_vga_fill_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, bus_gnt = 1'b0;
  logic [9:0]  x0 = '0, width = '0;
  logic [8:0]  y0 = '0, height = '0;
  logic [11:0] color = '0;
  logic        busy, done, err, bus_req, m_sel;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_we;

  vga_fill_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .width(width), .height(height), .color(color),
    .busy(busy), .done(done), .err(err), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .m_sel(m_sel), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int edges = 0, acc_edge = 0;
  int done_cnt = 0, done_cyc = 0, bad_wd = 0;
  logic done_err;
  logic [31:0] exp_wd;
  logic [31:0] wr_addr[$];
  int wr_cyc[$];
  int exp_idx[$];
  int exp_cyc[$];

  always @(posedge clk) edges <= edges + 1;

  // Writes and done are observed mid-cycle; cycle 0 is the accepting edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_sel) begin
        wr_addr.push_back(m_addr);
        wr_cyc.push_back(edges - acc_edge + 1);
        if (m_we !== 3'b100 || m_wdata !== exp_wd) bad_wd++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = edges - acc_edge + 1;
        done_err = err;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a command and return at cycle 1 (just after the accepting edge).
  task automatic issue(input int ix, input int iy, input int iw, input int ih, input int ic);
    x0 = 10'(ix); y0 = 9'(iy); width = 10'(iw); height = 9'(ih); color = 12'(ic);
    exp_wd = 32'(ic);
    wr_addr.delete(); wr_cyc.delete();
    done_cnt = 0; done_cyc = 0; bad_wd = 0;
    start = 1'b1;
    @(posedge clk); #1;
    acc_edge = edges;
    start = 1'b0;
  endtask

  // Returns one cycle after the done pulse, with the engine back in IDLE.
  task automatic wait_done(input string tag);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_writes(input string tag);
    chk({tag, "_nwr"}, wr_addr.size(), exp_idx.size());
    for (int i = 0; i < exp_idx.size() && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'h0010_0000 + 32'(exp_idx[i]));
      chk($sformatf("%s_cyc%0d", tag, i), wr_cyc[i], exp_cyc[i]);
    end
    chk({tag, "_we_wdata"}, bad_wd, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_sel", m_sel, 0);
    chk("rst_we", m_we, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic fill
    bus_gnt = 1'b1;
    issue(2, 1, 3, 2, 12'hF0A);
    chk("basic_busy_c1", busy, 1);
    wait_done("basic");
    exp_idx = '{642, 643, 644, 1282, 1283, 1284};
    exp_cyc = '{2, 3, 4, 5, 6, 7};
    chk_writes("basic");
    chk("basic_done_cyc", done_cyc, 8);
    chk("basic_err", done_err, 0);

    // Grant stall for cycles 4..6, plus a start pulse while busy
    issue(2, 1, 3, 2, 12'hF0A);
    repeat (3) @(posedge clk);
    #1;
    bus_gnt = 1'b0;
    start = 1'b1; x0 = 10'd100;
    @(posedge clk); #1;
    start = 1'b0;
    chk("stall_sel_low", m_sel, 0);
    chk("stall_req_high", bus_req, 1);
    repeat (2) @(posedge clk);
    #1;
    bus_gnt = 1'b1;
    wait_done("stall");
    repeat (4) @(posedge clk);
    #1;
    exp_cyc = '{2, 3, 7, 8, 9, 10};
    chk_writes("stall");
    chk("stall_done_cyc", done_cyc, 11);
    chk("stall_one_done", done_cnt, 1);
    chk("stall_idle", busy, 0);

    // Clipping at bottom-right corner
    issue(638, 479, 10, 10, 12'h123);
    wait_done("clip");
    exp_idx = '{307198, 307199};
    exp_cyc = '{2, 3};
    chk_writes("clip");
    chk("clip_done_cyc", done_cyc, 4);
    chk("clip_err", done_err, 0);

    // Off-screen origin
    issue(640, 0, 5, 5, 12'h555);
    wait_done("offs");
    chk("offs_nwr", wr_addr.size(), 0);
    chk("offs_done_cyc", done_cyc, 2);
    chk("offs_err", done_err, 1);
    chk("offs_err_sticky", err, 1);

    // Zero width
    issue(0, 0, 0, 5, 12'h555);
    wait_done("zero");
    chk("zero_nwr", wr_addr.size(), 0);
    chk("zero_done_cyc", done_cyc, 2);
    chk("zero_err", done_err, 0);

    // Abort: grant low in WRITE cycle 1, writes in 2 and 3, abort in 4
    issue(0, 0, 100, 1, 12'h0AB);
    bus_gnt = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    #3;
    chk("abort_sel_low", m_sel, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done("abort");
    exp_idx = '{0, 1};
    exp_cyc = '{3, 4};
    chk_writes("abort");
    chk("abort_done_cyc", done_cyc, 6);
    chk("abort_err", done_err, 1);
    chk("abort_req_after", bus_req, 0);

    // Reset mid-fill
    issue(0, 0, 100, 10, 12'hFFF);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_sel_before", m_sel, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_sel", m_sel, 0);
    chk("midrst_req", bus_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", m_addr, 0);
    chk("midrst_we", m_we, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, 0);
    issue(5, 0, 1, 1, 12'h00F);
    wait_done("postrst");
    exp_idx = '{5};
    exp_cyc = '{2};
    chk_writes("postrst");
    chk("postrst_done_cyc", done_cyc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_fill_engine.md
Name: vga_fill_engine

Overview:
Bus-master rectangle fill engine that sits directly upstream of the VGA controller's local-bus slave. It writes a solid 12-bit RGB colour into every VRAM pixel of a clipped rectangle. Each pixel is one single-cycle VRAM write through the controller's VRAM window. It shares the local bus with the CPU through a req/gnt handshake, which offloads screen clears and box draws from software.

Parameters:
XLEN, 32, local bus data/address width (from core_general.vh)
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
VRAM_BASE, 32'h0010_0000, bus address of VRAM pixel 0 (the controller's VRAM window; pixel index in addr[18:0])

Ports:
clk  in  1  global clock, same domain as the VGA controller bus side
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
abort  in  1  cancel the fill in progress
x0  in  10  rectangle left column
y0  in  9  rectangle top line
width  in  10  columns to fill
height  in  9  lines to fill
color  in  12  {R[3:0],G[3:0],B[3:0]}
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
err  out  1  sticky status of the last command: 1 = origin off-screen or aborted; updated at done
bus_req  out  1  local bus request
bus_gnt  in  1  local bus grant from the arbiter
m_sel  out  1  bus select, to the controller's sel
m_addr  out  XLEN  bus address, to the controller's addr
m_we  out  3  write enable, to the controller's we (3'b100 = write)
m_wdata  out  XLEN  write data, to the controller's qin

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, err, bus_req, m_sel = 0; m_we = 0; m_addr = 0; m_wdata = 0. Reset mid-fill abandons the fill and produces no done pulse.
- States: IDLE, CALC, WRITE, FIN.
- IDLE: on start=1, latch x0, y0, width, height, color and go to CALC. start in any other state is ignored.
- CALC (1 cycle, busy=1):
  - Compute xe = min(x0+width, H_ACTIVE) and ye = min(y0+height, V_ACTIVE), using 11-bit sums with no wrap.
  - Compute row base = y0*H_ACTIVE + x0 as a 19-bit value.
  - If x0>=H_ACTIVE or y0>=V_ACTIVE: go to FIN with err=1.
  - Else if width==0 or height==0: go to FIN with err=0.
  - Else go to WRITE.
- WRITE:
  - bus_req=1 for the whole state.
  - m_sel = bus_gnt (combinational); m_we = bus_gnt ? 3'b100 : 3'b000.
  - m_addr = VRAM_BASE | pixel index; m_wdata = {zeros, color}.
  - A write is accepted on each cycle with bus_gnt=1, and only then does the x/y position advance.
  - Row advance: x wraps to the clipped x start, and the row base += H_ACTIVE (no multiplier in the loop).
  - Pixel order: raster order, left to right, then top to bottom.
  - When bus_gnt drops, hold the current pixel and retry it on the next granted cycle. No pixel is skipped or duplicated.
  - After the write of the pixel at (xe-1, ye-1) is accepted, go to FIN.
- FIN (1 cycle): bus_req=0, m_sel=0, done=1, busy=0, err updated, then return to IDLE.
- abort=1 in CALC or WRITE: no write is issued in that cycle (m_sel forced 0), then go to FIN with err=1. abort in IDLE or FIN has no effect.
- Latency: with bus_gnt held high, an N-pixel fill accepted at cycle 0 writes on cycles 2..N+1 and pulses done on cycle N+2.
- Clipping boundary: the right and bottom edges are clipped silently; err stays 0 when the origin is on-screen.
- The address never exceeds VRAM_BASE + H_ACTIVE*V_ACTIVE-1.

Test Plan:
- Reset mid-fill: assert rst_n=0 during WRITE -> all outputs 0 immediately; no done pulse; after release, IDLE accepts a new start.
- Basic fill: x0=2, y0=1, w=3, h=2, color=12'hF0A, gnt=1 -> six writes at pixel indices 642, 643, 644, 1282, 1283, 1284, each with m_addr=0x0010_0000+idx, m_we=3'b100, m_wdata=0xF0A. Writes on cycles 2-7, done on cycle 8.
- Grant stall: same command, drop bus_gnt for 3 cycles after the second write -> m_sel=0 during the stall; exactly six writes in order; done on cycle 11.
- Clipping: x0=638, y0=479, w=10, h=10 -> exactly two writes, at indices 307198 and 307199; err=0.
- Degenerate/illegal: x0=640 -> zero writes, done on cycle 2, err=1. Then x0=0 with w=0 -> zero writes, done, err=0. start pulsed while busy is ignored.
- Abort: abort in the fourth WRITE cycle of a 100-pixel fill -> exactly 2 writes, done on the next cycle, err=1, bus_req=0 after done.
